// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter and its encoders.
`timescale 1ns/1ps
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // {valid, index} for a one-hot vector; 000 for zero or multi-hot input.
  function automatic logic [IDX_W:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W:0] enc;
    case (oh)
      4'b0001: enc = 3'b100;
      4'b0010: enc = 3'b101;
      4'b0100: enc = 3'b110;
      4'b1000: enc = 3'b111;
      default: enc = 3'b000;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: scans req & ~mask from (last+1) mod 4, wrapping.
`timescale 1ns/1ps
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick_oh,
  output logic             pick_v
);

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] scan_idx;

  assign cand   = req & ~mask;
  assign pick_v = |cand;

  // Walk the scan order backwards so the earliest position in the order wins.
  always_comb begin
    pick_oh  = '0;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = last + IDX_W'(k + 1);
      if (cand[scan_idx]) pick_oh = N_REQ'(1) << scan_idx;
    end
  end

endmodule

// File: rtl/rr_arbiter_4x2.sv
// Round-robin arbiter, 4 requesters, registered one-hot grant plus {gnt_v, gnt_idx}.
`timescale 1ns/1ps
module rr_arbiter_4x2
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_v,
  output logic             busy
);

  // Protocol: requester i raises req[i] and keeps it high for as long as it wants or
  // uses the resource; gnt[i] means it owns the resource; dropping req[i] releases it.

  localparam bit          HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [CW-1:0]    hold_cnt, hold_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_v;
  logic [IDX_W:0]   pick_enc;
  logic [IDX_W:0]   gnt_enc_nxt;
  logic             owner_req;

  // Masking the current owner is a no-op in IDLE because gnt is zero there.
  rr_pick_4 u_pick (
    .req     (req),
    .mask    (gnt),
    .last    (last),
    .pick_oh (pick_oh),
    .pick_v  (pick_v)
  );

  assign pick_enc    = onehot_to_idx(pick_oh);
  assign gnt_enc_nxt = onehot_to_idx(gnt_nxt);
  assign owner_req   = |(req & gnt);
  assign busy        = (state == GRANT);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (pick_v) begin
          gnt_nxt   = pick_oh;
          last_nxt  = pick_enc[IDX_W-1:0];
          hold_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Release wins over timeout: hand over without a bubble, or go idle.
          hold_nxt = '0;
          if (pick_v) begin
            gnt_nxt  = pick_oh;
            last_nxt = pick_enc[IDX_W-1:0];
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
          hold_nxt = '0;
          if (pick_v) begin
            gnt_nxt  = pick_oh;
            last_nxt = pick_enc[IDX_W-1:0];
          end
        end else if (HOLD_EN) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_v    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= gnt_enc_nxt[IDX_W-1:0];
      gnt_v    <= gnt_enc_nxt[IDX_W];
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4x2.sv
// Directed bench for rr_arbiter_4x2: one instance at MAX_HOLD=8, one at MAX_HOLD=4.
`timescale 1ns/1ps
module tb_rr_arbiter_4x2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req2;
  logic [3:0] gnt, gnt2;
  logic [1:0] gnt_idx, gnt_idx2;
  logic       gnt_v, gnt_v2, busy, busy2;
  logic [3:0] req_q, req2_q;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rr_arbiter_4x2 #(.MAX_HOLD(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_v(gnt_v), .busy(busy)
  );

  rr_arbiter_4x2 #(.MAX_HOLD(4), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .req(req2),
    .gnt(gnt2), .gnt_idx(gnt_idx2), .gnt_v(gnt_v2), .busy(busy2)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh == (4'b0001 << i)) r = 2'(i);
    return r;
  endfunction

  // Invariants on both instances, sampled on the falling edge.
  always @(posedge clk) begin
    req_q  <= req;
    req2_q <= req2;
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("inv_onehot",  gnt & (gnt - 4'd1), 0);
      chk("inv_v",       gnt_v, (gnt != 4'd0));
      chk("inv_idx",     gnt_idx, enc(gnt));
      chk("inv_req",     gnt & ~req_q, 0);
      chk("inv4_onehot", gnt2 & (gnt2 - 4'd1), 0);
      chk("inv4_v",      gnt_v2, (gnt2 != 4'd0));
      chk("inv4_idx",    gnt_idx2, enc(gnt2));
      chk("inv4_req",    gnt2 & ~req2_q, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_chk(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                          input logic ev, input logic eb);
    @(negedge clk);
    chk({tag, "_gnt"},  gnt, eg);
    chk({tag, "_idx"},  gnt_idx, ei);
    chk({tag, "_v"},    gnt_v, ev);
    chk({tag, "_busy"}, busy, eb);
  endtask

  task automatic tick_chk4(input string tag, input logic [3:0] eg, input logic [1:0] ei);
    @(negedge clk);
    chk({tag, "_gnt"}, gnt2, eg);
    chk({tag, "_idx"}, gnt_idx2, ei);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] eg;
    logic [1:0] ei;
    rst  = 1'b1;
    req  = 4'b1111;
    req2 = 4'b0000;

    // Reset holds everything at zero even with all requests up.
    repeat (2) tick_chk("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("rst4_gnt", gnt2, 0);
    chk("rst4_busy", busy2, 0);
    rst = 1'b0;

    // Fairness / timeout: 8 cycles each in order 0,1,2,3 then back to 0.
    for (int k = 0; k <= 32; k++) begin
      eg = (k < 32) ? (4'b0001 << (k / 8)) : 4'b0001;
      ei = (k < 32) ? 2'(k / 8) : 2'd0;
      tick_chk("fair", eg, ei, 1'b1, 1'b1);
    end
    chk("d4_idle_gnt", gnt2, 0);
    chk("d4_idle_busy", busy2, 0);

    req = 4'b0000;
    tick_chk("drop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester for 3 cycles then release.
    req = 4'b0100;
    repeat (3) tick_chk("single", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    tick_chk("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Handover 1 -> 3 with no zero-grant cycle.
    req = 4'b0010;
    tick_chk("ho_grant", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1010;
    tick_chk("ho_wait", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1000;
    tick_chk("handover", 4'b1000, 2'd3, 1'b1, 1'b1);

    // Async reset between edges while gnt=1000.
    #2 rst = 1'b1;
    req = 4'b1111;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_idx", gnt_idx, 0);
    chk("arst_v", gnt_v, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick_chk("rst_restart", 4'b0001, 2'd0, 1'b1, 1'b1);
    req = 4'b0000;

    // MAX_HOLD=4 sole owner keeps the grant through its timeouts.
    req2 = 4'b0010;
    for (int k = 0; k < 10; k++) tick_chk4("sole", 4'b0010, 2'd1);

    // Others arrive with hold_cnt=1: two more cycles, then rotate to 3, then to 0.
    req2 = 4'b1011;
    repeat (2) tick_chk4("rot_hold", 4'b0010, 2'd1);
    repeat (4) tick_chk4("rot_3", 4'b1000, 2'd3);
    tick_chk4("rot_0", 4'b0001, 2'd0);

    req2 = 4'b0000;
    tick_chk4("d4_rel", 4'b0000, 2'd0);
    chk("d4_rel_busy", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
